sn_out_eval: RTL and testbench

SN_OUT_EVAL -- requirements
Module: sn_out_eval

---
 rtl/sn_pkg.sv | 23 ++
 rtl/sn_out_eval_if.sv | 51 +++++
 rtl/sn_sat_cntr.sv | 35 +++
 rtl/sn_out_eval.sv | 168 ++++++++++++++++
 tb/tb_sn_out_eval.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sn_pkg.sv
// sn_pkg: shared types and width helpers for the spiking-network output
// evaluator.
//   sn_oe_state_t : evaluator FSM states (IDLE, ACCUM, SCAN, HOLD)
//   sn_cnt_w(m)   : bits needed to hold a count of 0..m
//   sn_idx_w(n)   : bits needed to index n items (never less than 1)
package sn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    HOLD  = 2'd3
  } sn_oe_state_t;

  function automatic int sn_cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int sn_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sn_out_eval_if.sv
// sn_out_eval_if: bundle between network controller / result consumer and
// the output evaluator.
//   nc_reset, nc_evaluate, nc_io_done, nc_io_cur_per : controller side
//   net_outputs                                      : output-neuron spikes
//   oe_rdy / oe_vld                                  : result handshake
//   oe_winner, oe_win_cnt, oe_none, oe_counts        : result and live counts
//   oe_first_per : only when SN_OUT_EVAL_FIRST_SPIKE_EN is defined
// Modports: slave = evaluator, master = controller/consumer.
interface sn_out_eval_if #(
  parameter int P_NUM_OUTPUTS     = 3,
  parameter int P_MAX_NUM_PERIODS = 100
);
  import sn_pkg::*;

  localparam int CW = sn_cnt_w(P_MAX_NUM_PERIODS);
  localparam int IW = sn_idx_w(P_NUM_OUTPUTS);

  logic                              nc_reset;
  logic                              nc_evaluate;
  logic [P_NUM_OUTPUTS-1:0]          net_outputs;
  logic                              nc_io_done;
  logic [CW-1:0]                     nc_io_cur_per;
  logic                              oe_rdy;
  logic                              oe_vld;
  logic [IW-1:0]                     oe_winner;
  logic [CW-1:0]                     oe_win_cnt;
  logic                              oe_none;
  logic [P_NUM_OUTPUTS-1:0][CW-1:0]  oe_counts;
`ifdef SN_OUT_EVAL_FIRST_SPIKE_EN
  logic [P_NUM_OUTPUTS-1:0][CW-1:0]  oe_first_per;

  modport slave (
    input  nc_reset, nc_evaluate, net_outputs, nc_io_done, nc_io_cur_per, oe_rdy,
    output oe_vld, oe_winner, oe_win_cnt, oe_none, oe_counts, oe_first_per
  );
  modport master (
    output nc_reset, nc_evaluate, net_outputs, nc_io_done, nc_io_cur_per, oe_rdy,
    input  oe_vld, oe_winner, oe_win_cnt, oe_none, oe_counts, oe_first_per
  );
`else
  modport slave (
    input  nc_reset, nc_evaluate, net_outputs, nc_io_done, nc_io_cur_per, oe_rdy,
    output oe_vld, oe_winner, oe_win_cnt, oe_none, oe_counts
  );
  modport master (
    output nc_reset, nc_evaluate, net_outputs, nc_io_done, nc_io_cur_per, oe_rdy,
    input  oe_vld, oe_winner, oe_win_cnt, oe_none, oe_counts
  );
`endif

endinterface

// File: rtl/sn_sat_cntr.sv
// sn_sat_cntr: saturating up-counter.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : count up by one unless already at P_MAX
//   cnt      : current count
module sn_sat_cntr #(
  parameter int P_WIDTH = 7,
  parameter int P_MAX   = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [P_WIDTH-1:0] cnt
);

  logic [P_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != P_WIDTH'(P_MAX))) begin
      cnt_d = cnt_q + P_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sn_out_eval.sv
// sn_out_eval: counts output-neuron spikes over a network run, then scans
// the counters one per cycle to pick the winner and holds the result until
// the consumer accepts it.
//   clk, rst : clock, synchronous active-high reset
//   io       : sn_out_eval_if.slave (controller pulses, spikes, result)
// Optional feature macro SN_OUT_EVAL_FIRST_SPIKE_EN: records the period of
// each output's first counted spike (oe_first_per) and uses it to break
// count ties in favour of the earlier spiker.
module sn_out_eval
  import sn_pkg::*;
#(
  parameter int P_NUM_OUTPUTS     = 3,
  parameter int P_MAX_NUM_PERIODS = 100
) (
  input  logic          clk,
  input  logic          rst,
  sn_out_eval_if.slave  io
);

  localparam int N  = P_NUM_OUTPUTS;
  localparam int CW = sn_cnt_w(P_MAX_NUM_PERIODS);
  localparam int IW = sn_idx_w(P_NUM_OUTPUTS);

  sn_oe_state_t          state_q, state_d;
  logic                  eval_dly_q;
  logic [IW-1:0]         idx_q, best_idx_q;
  logic [CW-1:0]         best_cnt_q, best_cnt_nx, cur_cnt;
  logic                  none_q;
  logic                  accum, scan_en, hold, scan_last, upd;
  logic [N-1:0]          inc;
  logic [N-1:0][CW-1:0]  cnt;

  // Per-output saturating spike counters
  for (genvar i = 0; i < N; i++) begin : g_cnt
    sn_sat_cntr #(.P_WIDTH(CW), .P_MAX(P_MAX_NUM_PERIODS)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (io.nc_reset),
      .inc (inc[i]),
      .cnt (cnt[i])
    );
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; nc_reset restarts accumulation from any state
  always_comb begin
    state_d = state_q;
    if (io.nc_reset) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (io.nc_io_done) state_d = SCAN;
        SCAN:    if (scan_last) state_d = HOLD;
        HOLD:    if (io.oe_rdy) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    accum     = (state_q == ACCUM);
    scan_en   = (state_q == SCAN);
    hold      = (state_q == HOLD);
    scan_last = scan_en && (idx_q == IW'(N - 1));
  end

  // The sample one cycle after nc_evaluate still counts on the nc_io_done
  // edge, so SCAN always sees the final totals; nc_reset discards it.
  always_comb begin
    inc = '0;
    if (accum && eval_dly_q && !io.nc_reset) inc = io.net_outputs;
  end

  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) cur_cnt = cnt[i];
    end
  end

`ifdef SN_OUT_EVAL_FIRST_SPIKE_EN
  logic [N-1:0][CW-1:0]  first_q;
  logic [CW-1:0]         best_first_q, cur_first;

  // A counter still at zero means this is the output's first counted spike
  always_ff @(posedge clk) begin
    if (rst) begin
      first_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (io.nc_reset)                  first_q[i] <= '0;
        else if (inc[i] && (cnt[i] == '0)) first_q[i] <= io.nc_io_cur_per;
      end
    end
  end

  always_comb begin
    cur_first = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) cur_first = first_q[i];
    end
  end

  // Equal nonzero counts: the earlier nonzero first-spike period wins;
  // equal periods keep the lower index already held.
  always_comb begin
    upd = (cur_cnt > best_cnt_q) ||
          ((cur_cnt == best_cnt_q) && (cur_cnt != '0) && (cur_first != '0) &&
           ((best_first_q == '0) || (cur_first < best_first_q)));
  end

  always_ff @(posedge clk) begin
    if (rst)                         best_first_q <= '0;
    else if (io.nc_reset)            best_first_q <= '0;
    else if (accum && io.nc_io_done) best_first_q <= '0;
    else if (scan_en && upd)         best_first_q <= cur_first;
  end

  assign io.oe_first_per = first_q;
`else
  // Strictly greater only, so ties stay with the lowest index
  always_comb begin
    upd = (cur_cnt > best_cnt_q);
  end
`endif

  always_comb begin
    best_cnt_nx = upd ? cur_cnt : best_cnt_q;
  end

  // Delayed evaluate, scan index and running/held result
  always_ff @(posedge clk) begin
    if (rst) begin
      eval_dly_q <= 1'b0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      none_q     <= 1'b0;
    end else begin
      eval_dly_q <= accum && io.nc_evaluate && !io.nc_reset;
      if (io.nc_reset || (accum && io.nc_io_done)) begin
        idx_q      <= '0;
        best_idx_q <= '0;
        best_cnt_q <= '0;
        none_q     <= 1'b0;
      end else if (scan_en) begin
        idx_q      <= idx_q + IW'(1);
        best_cnt_q <= best_cnt_nx;
        if (upd) best_idx_q <= idx_q;
        if (scan_last) none_q <= (best_cnt_nx == '0);
      end
    end
  end

  assign io.oe_vld     = hold;
  assign io.oe_winner  = best_idx_q;
  assign io.oe_win_cnt = best_cnt_q;
  assign io.oe_none    = none_q;
  assign io.oe_counts  = cnt;

endmodule

// File: tb/tb_sn_out_eval.sv
module tb_sn_out_eval;

  localparam int N  = 3;
  localparam int MX = 100;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sn_out_eval_if #(.P_NUM_OUTPUTS(N), .P_MAX_NUM_PERIODS(MX)) bus ();

  sn_out_eval #(.P_NUM_OUTPUTS(N), .P_MAX_NUM_PERIODS(MX)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    int c0, c1, c2;       // spikes driven per output
    int ew, ecnt, enone;  // expected winner, win count, none flag
    int k0, k1, k2;       // expected live counters
  } vec_t;

  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_run();
    bus.nc_reset = 1'b1;
    tick();
    bus.nc_reset = 1'b0;
  endtask

  // evaluate pulse, then spikes presented on the following cycle
  task automatic do_eval(input logic [N-1:0] pat, input int per);
    bus.nc_io_cur_per = 7'(per);
    bus.nc_evaluate   = 1'b1;
    tick();
    bus.nc_evaluate = 1'b0;
    bus.net_outputs = pat;
    tick();
    bus.net_outputs = '0;
  endtask

  task automatic run_counts(input int c0, input int c1, input int c2);
    int m;
    logic [N-1:0] pat;
    m = c0;
    if (c1 > m) m = c1;
    if (c2 > m) m = c2;
    for (int k = 0; k < m; k++) begin
      pat = {(k < c2), (k < c1), (k < c0)};
      do_eval(pat, k + 1);
    end
  endtask

  task automatic issue_done();
    bus.nc_io_done = 1'b1;
    tick();
    bus.nc_io_done = 1'b0;
  endtask

  // called right after the nc_io_done cycle; latency counts that cycle
  task automatic check_result(input string name, input int ew, input int ecnt,
                              input int enone, input bit accept);
    int lat;
    lat = 1;
    while (!bus.oe_vld && lat < 20) begin
      tick();
      lat++;
    end
    chk({name, ".latency"}, lat, N + 1);
    chk({name, ".winner"},  int'(bus.oe_winner),  ew);
    chk({name, ".win_cnt"}, int'(bus.oe_win_cnt), ecnt);
    chk({name, ".none"},    int'(bus.oe_none),    enone);
    if (accept) begin
      bus.oe_rdy = 1'b1;
      tick();
      bus.oe_rdy = 1'b0;
      chk({name, ".vld_after_accept"}, int'(bus.oe_vld), 0);
    end
  endtask

  task automatic chk_counts(input string name, input int k0, input int k1, input int k2);
    chk({name, ".cnt0"}, int'(bus.oe_counts[0]), k0);
    chk({name, ".cnt1"}, int'(bus.oe_counts[1]), k1);
    chk({name, ".cnt2"}, int'(bus.oe_counts[2]), k2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [N-1:0] per_pat [10];

    vecs[0] = '{c0:0,   c1:5,   c2:0,   ew:1, ecnt:5,   enone:0, k0:0,   k1:5,   k2:0};
    vecs[1] = '{c0:0,   c1:0,   c2:0,   ew:0, ecnt:0,   enone:1, k0:0,   k1:0,   k2:0};
    vecs[2] = '{c0:3,   c1:1,   c2:2,   ew:0, ecnt:3,   enone:0, k0:3,   k1:1,   k2:2};
    vecs[3] = '{c0:1,   c1:2,   c2:6,   ew:2, ecnt:6,   enone:0, k0:1,   k1:2,   k2:6};
    vecs[4] = '{c0:120, c1:120, c2:120, ew:0, ecnt:100, enone:0, k0:100, k1:100, k2:100};
    vecs[5] = '{c0:4,   c1:4,   c2:1,   ew:0, ecnt:4,   enone:0, k0:4,   k1:4,   k2:1};

    rst               = 1'b1;
    bus.nc_reset      = 1'b0;
    bus.nc_evaluate   = 1'b0;
    bus.net_outputs   = '0;
    bus.nc_io_done    = 1'b0;
    bus.nc_io_cur_per = '0;
    bus.oe_rdy        = 1'b0;
    repeat (3) tick();
    chk("reset.vld",     int'(bus.oe_vld),     0);
    chk("reset.winner",  int'(bus.oe_winner),  0);
    chk("reset.win_cnt", int'(bus.oe_win_cnt), 0);
    chk("reset.none",    int'(bus.oe_none),    0);
    chk_counts("reset", 0, 0, 0);
    rst = 1'b0;
    tick();

    // table-driven runs
    for (int v = 0; v < 6; v++) begin
      start_run();
      run_counts(vecs[v].c0, vecs[v].c1, vecs[v].c2);
      chk_counts($sformatf("vec%0d", v), vecs[v].k0, vecs[v].k1, vecs[v].k2);
      issue_done();
      check_result($sformatf("vec%0d", v), vecs[v].ew, vecs[v].ecnt, vecs[v].enone, 1'b1);
    end

    // back in IDLE: evaluates and nc_io_done are ignored, counters kept
    do_eval(3'b111, 1);
    chk_counts("idle_eval", 4, 4, 1);
    issue_done();
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.oe_vld) seen++;
    end
    chk("idle_done.vld_seen", seen, 0);

    // tie {2,4,4}; first spikes out0@8, out1@7, out2@3
    per_pat = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b100,
                3'b100, 3'b010, 3'b011, 3'b011, 3'b010};
    start_run();
    for (int p = 0; p < 10; p++) do_eval(per_pat[p], p + 1);
    chk_counts("tie", 2, 4, 4);
`ifdef SN_OUT_EVAL_FIRST_SPIKE_EN
    chk("tie.first0", int'(bus.oe_first_per[0]), 8);
    chk("tie.first1", int'(bus.oe_first_per[1]), 7);
    chk("tie.first2", int'(bus.oe_first_per[2]), 3);
    issue_done();
    check_result("tie", 2, 4, 0, 1'b1);
`else
    issue_done();
    check_result("tie", 1, 4, 0, 1'b1);
`endif

    // delayed sample lands in the same cycle as nc_io_done and is counted
    start_run();
    do_eval(3'b001, 1);
    bus.nc_evaluate = 1'b1;
    tick();
    bus.nc_evaluate = 1'b0;
    bus.net_outputs = 3'b001;
    bus.nc_io_done  = 1'b1;
    tick();
    bus.net_outputs = '0;
    bus.nc_io_done  = 1'b0;
    check_result("coincide", 0, 2, 0, 1'b0);
    chk_counts("coincide", 2, 0, 0);
    bus.oe_rdy = 1'b1;
    tick();
    bus.oe_rdy = 1'b0;

    // stall in HOLD, then nc_reset drops the held result
    start_run();
    run_counts(0, 5, 0);
    issue_done();
    check_result("hold", 1, 5, 0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("hold%0d.vld", c),     int'(bus.oe_vld),     1);
      chk($sformatf("hold%0d.winner", c),  int'(bus.oe_winner),  1);
      chk($sformatf("hold%0d.win_cnt", c), int'(bus.oe_win_cnt), 5);
      chk($sformatf("hold%0d.none", c),    int'(bus.oe_none),    0);
    end
    start_run();
    chk("hold_reset.vld", int'(bus.oe_vld), 0);
    chk_counts("hold_reset", 0, 0, 0);
    do_eval(3'b100, 1);
    issue_done();
    check_result("after_hold_reset", 2, 1, 0, 1'b1);

    // nc_reset together with nc_io_done: stays accumulating, counters cleared
    start_run();
    run_counts(2, 2, 2);
    bus.nc_reset   = 1'b1;
    bus.nc_io_done = 1'b1;
    tick();
    bus.nc_reset   = 1'b0;
    bus.nc_io_done = 1'b0;
    chk_counts("rst_done", 0, 0, 0);
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.oe_vld) seen++;
    end
    chk("rst_done.vld_seen", seen, 0);
    do_eval(3'b100, 1);
    issue_done();
    check_result("rst_done_run", 2, 1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
